keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, the 4x4 code map and scanner state encoding.
package keypad_pkg;

    localparam logic [4:0] KEY_PWR  = 5'd10;
    localparam logic [4:0] KEY_STB  = 5'd13;
    localparam logic [4:0] KEY_NO   = 5'd14;
    localparam logic [4:0] KEY_YES  = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd31;

    typedef enum logic [1:0] {
        StScan,
        StDbPress,
        StHeld,
        StDbRel
    } scan_state_e;

    // Code for the key at (row, col) on the membrane keypad.
    function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [4:0] code;
        unique case ({row, col})
            4'h0: code = 5'd1;
            4'h1: code = 5'd2;
            4'h2: code = 5'd3;
            4'h3: code = KEY_PWR;   // A
            4'h4: code = 5'd4;
            4'h5: code = 5'd5;
            4'h6: code = 5'd6;
            4'h7: code = 5'd11;     // B
            4'h8: code = 5'd7;
            4'h9: code = 5'd8;
            4'hA: code = 5'd9;
            4'hB: code = 5'd12;     // C
            4'hC: code = KEY_NO;    // *
            4'hD: code = 5'd0;
            4'hE: code = KEY_YES;   // #
            4'hF: code = KEY_STB;   // D
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Index of the lowest-numbered low (active) row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle rows).
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture to resolve metastability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, press/release debounce and key decode.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 27000,
    parameter int unsigned DEBOUNCE_N = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       keypad_pressed,
    output logic [4:0] key,
    output logic       key_valid
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned MW = $clog2(DEBOUNCE_N + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_N);

    scan_state_e r_state;
    scan_state_e w_state_d;
    logic [DW-1:0] r_dwell;
    logic [MW-1:0] r_match;
    logic [MW-1:0] w_match_d;
    logic [MW-1:0] w_match_inc;
    logic [1:0]    r_col;
    logic [1:0]    w_col_next;
    logic [3:0]    r_col_out;
    logic [1:0]    r_row;
    logic [1:0]    w_row_d;
    logic          r_key_valid;
    logic          w_advance;
    logic          w_sample;
    logic          w_any_low;
    logic [1:0]    w_low_row;
    logic [3:0]    w_rows;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (row_in),
        .o_q     (w_rows)
    );

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_any_low   = ~&w_rows;
    assign w_low_row   = lowest_low(w_rows);
    assign w_match_inc = r_match + 1'b1;
    assign w_col_next  = r_col + 2'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StScan;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and match-count decisions, taken only on the last dwell cycle.
    always_comb begin
        w_state_d = r_state;
        w_match_d = r_match;
        w_row_d   = r_row;
        w_advance = 1'b0;
        if (w_sample) begin
            unique case (r_state)
                StScan: begin
                    if (w_any_low) begin
                        w_row_d   = w_low_row;
                        w_match_d = MW'(1);
                        w_state_d = StDbPress;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                StDbPress: begin
                    if (!w_any_low) begin
                        w_match_d = '0;
                        w_state_d = StScan;
                        w_advance = 1'b1;
                    end else if (w_low_row == r_row) begin
                        if (w_match_inc == MATCH_DONE) begin
                            w_match_d = '0;
                            w_state_d = StHeld;
                        end else begin
                            w_match_d = w_match_inc;
                        end
                    end else begin
                        // A different row took over: restart debounce on it.
                        w_row_d   = w_low_row;
                        w_match_d = MW'(1);
                    end
                end
                StHeld: begin
                    if (!w_any_low) begin
                        w_match_d = MW'(1);
                        w_state_d = StDbRel;
                    end
                end
                StDbRel: begin
                    if (w_any_low) begin
                        w_match_d = '0;
                        w_state_d = StHeld;
                    end else if (w_match_inc == MATCH_DONE) begin
                        w_match_d = '0;
                        w_state_d = StScan;
                        w_advance = 1'b1;
                    end else begin
                        w_match_d = w_match_inc;
                    end
                end
                default: begin
                    w_match_d = '0;
                    w_state_d = StScan;
                end
            endcase
        end
    end

    // Dwell timer, column drive, candidate row, match count and the press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell     <= '0;
            r_match     <= '0;
            r_col       <= 2'd0;
            r_col_out   <= 4'b1110;
            r_row       <= 2'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_dwell     <= w_sample ? '0 : r_dwell + 1'b1;
            r_match     <= w_match_d;
            r_row       <= w_row_d;
            r_key_valid <= (r_state == StDbPress) && (w_state_d == StHeld);
            if (w_advance) begin
                r_col     <= w_col_next;
                r_col_out <= ~(4'b0001 << w_col_next);
            end
        end
    end

    // Outputs decoded from registered state; a held key stays reported through release debounce.
    always_comb begin
        keypad_pressed = (r_state == StHeld) || (r_state == StDbRel);
        key            = keypad_pressed ? key_code(r_row, r_col) : KEY_NONE;
        key_valid      = r_key_valid;
        col_out        = r_col_out;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a key_valid scoreboard.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV   = 8;
    localparam int unsigned DEBOUNCE_N = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       keypad_pressed;
    logic [4:0] key;
    logic       key_valid;

    logic [15:0] keys;      // pressed keys, index row*4+col
    int          checks;
    int          errors;
    int          kv_count;
    int          exp_q[$];

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .row_in         (row_in),
        .col_out        (col_out),
        .keypad_pressed (keypad_pressed),
        .key            (key),
        .key_valid      (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Membrane matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pressed(input logic lvl, input int limit, input string tag);
        int n;
        n = 0;
        while (keypad_pressed !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(keypad_pressed), 32'(lvl));
    endtask

    initial begin
        int         kv0;
        int         drops;
        int         n;
        logic [3:0] exp_col;

        checks   = 0;
        errors   = 0;
        kv_count = 0;
        keys     = '0;
        rst_n    = 1'b0;

        // Scoreboard: every key_valid pops the code queued when its key was pressed.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && key_valid) begin
                    kv_count++;
                    check("kv_with_pressed", 32'(keypad_pressed), 32'd1);
                    check("kv_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("kv_key", 32'(key), 32'(exp_q.pop_front()));
                end
            end
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_out), 32'b1110);
        check("rst_pressed", 32'(keypad_pressed), 32'd0);
        check("rst_key", 32'(key), 32'd31);
        check("rst_kv", 32'(key_valid), 32'd0);

        // Idle column rotation, 8 clk per column.
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("col_0", 32'(col_out), 32'b1110);
        for (int i = 1; i <= 4; i++) begin
            repeat (8) @(negedge clk);
            exp_col = ~(4'b0001 << (i % 4));
            check("col_rot", 32'(col_out), 32'(exp_col));
        end
        check("idle_pressed", 32'(keypad_pressed), 32'd0);
        check("idle_key", 32'(key), 32'd31);

        // Clean press and release of '6' (r1/c2).
        kv0 = kv_count;
        exp_q.push_back(6);
        keys[6] = 1'b1;
        wait_pressed(1'b1, 56, "press6_latency");
        check("press6_key", 32'(key), 32'd6);
        repeat (10) @(negedge clk);
        keys[6] = 1'b0;
        wait_pressed(1'b0, 28, "release6_latency");
        check("release6_key", 32'(key), 32'd31);
        check("press6_kv_once", 32'(kv_count - kv0), 32'd1);
        repeat (40) @(negedge clk);

        // Bouncy press of D (r3/c3): five 3-clk segments then steady.
        kv0 = kv_count;
        exp_q.push_back(13);
        for (int i = 0; i < 5; i++) begin
            keys[15] = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        keys[15] = 1'b1;
        wait_pressed(1'b1, 200, "bounce_press");
        check("bounce_key", 32'(key), 32'd13);
        drops = 0;
        repeat (40) begin
            @(negedge clk);
            if (!keypad_pressed) drops++;
        end
        check("bounce_no_drop", 32'(drops), 32'd0);
        check("bounce_kv_once", 32'(kv_count - kv0), 32'd1);
        keys[15] = 1'b0;
        wait_pressed(1'b0, 28, "bounce_release");
        repeat (40) @(negedge clk);

        // Mid-hold release glitch on # (r3/c2) must not drop the press.
        kv0 = kv_count;
        exp_q.push_back(15);
        keys[14] = 1'b1;
        wait_pressed(1'b1, 100, "yes_press");
        check("yes_key", 32'(key), 32'd15);
        repeat (5) @(negedge clk);
        drops = 0;
        keys[14] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (!keypad_pressed) drops++;
        end
        keys[14] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!keypad_pressed) drops++;
        end
        check("glitch_no_drop", 32'(drops), 32'd0);
        check("glitch_key", 32'(key), 32'd15);
        check("glitch_kv_once", 32'(kv_count - kv0), 32'd1);
        keys[14] = 1'b0;
        wait_pressed(1'b0, 28, "yes_release");
        repeat (40) @(negedge clk);

        // * and 7 together in column 0: row 2 beats row 3.
        exp_q.push_back(7);
        keys[12] = 1'b1;
        keys[8]  = 1'b1;
        wait_pressed(1'b1, 100, "same_col_press");
        check("same_col_key", 32'(key), 32'd7);
        keys[12] = 1'b0;
        keys[8]  = 1'b0;
        wait_pressed(1'b0, 28, "same_col_release");
        repeat (40) @(negedge clk);

        // Hold 1 (c0) then press 2 (c1): first column keeps ownership.
        kv0 = kv_count;
        exp_q.push_back(1);
        keys[0] = 1'b1;
        wait_pressed(1'b1, 100, "one_press");
        check("one_key", 32'(key), 32'd1);
        keys[1] = 1'b1;
        repeat (40) @(negedge clk);
        check("one_over_two_key", 32'(key), 32'd1);
        check("one_over_two_kv", 32'(kv_count - kv0), 32'd1);
        keys[0] = 1'b0;
        keys[1] = 1'b0;
        wait_pressed(1'b0, 28, "one_release");
        repeat (40) @(negedge clk);

        // Reset while A (r0/c3) is held, then a fresh debounce after reset.
        exp_q.push_back(10);
        keys[3] = 1'b1;
        wait_pressed(1'b1, 100, "pwr_press");
        check("pwr_key", 32'(key), 32'd10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_col", 32'(col_out), 32'b1110);
        check("midrst_pressed", 32'(keypad_pressed), 32'd0);
        check("midrst_key", 32'(key), 32'd31);
        check("midrst_kv", 32'(key_valid), 32'd0);
        @(negedge clk);
        exp_q.push_back(10);
        rst_n = 1'b1;
        n = 0;
        while (keypad_pressed !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pwr_repress", 32'(keypad_pressed), 32'd1);
        check("pwr_fresh_debounce", 32'(n >= DEBOUNCE_N * SCAN_DIV), 32'd1);
        check("pwr_repress_key", 32'(key), 32'd10);
        keys[3] = 1'b0;
        wait_pressed(1'b0, 28, "pwr_release");
        repeat (10) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
